// File: rtl/fi_pkg.sv
// fi_pkg: shared fault modes, channel states and the corruption function.
// FI_HITCOUNT_EN selects the optional per-channel hit counter.
package fi_pkg;
  localparam int FI_MODE_W = 2;
  localparam int FI_MAX_W = 1024;
`ifdef FI_HITCOUNT_EN
  localparam bit FI_HIT_EN = 1'b1;
`else
  localparam bit FI_HIT_EN = 1'b0;
`endif
  typedef enum logic [FI_MODE_W-1:0] {FI_FLIP, FI_SA0, FI_SA1, FI_DISARM} fi_mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_ACTIVE} fi_state_e;
  // Operates at FI_MAX_W bits; callers zero-extend and truncate to their bus width.
  function automatic logic [FI_MAX_W-1:0] fi_apply(input logic [FI_MAX_W-1:0] d, input logic [FI_MAX_W-1:0] m, input fi_mode_e mode);
    return mode == FI_FLIP ? d ^ m : mode == FI_SA0 ? d & ~m : mode == FI_SA1 ? d | m : d;
  endfunction
endpackage

// File: rtl/fi_channel.sv
// fi_channel: one injection channel (FSM, latched config, duration counter).
// Ports: clk/rst, i_we/i_mode/i_mask/i_start/i_dur config write, i_cnt shared
// cycle count, i_data bus in; o_data possibly corrupted bus, o_apply corrupting
// now, o_done last cycle of a finite fault, o_hits (FI_HITCOUNT_EN) data-changing cycles.
module fi_channel
  import fi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  fi_mode_e          i_mode,
  input  logic [DATA_W-1:0] i_mask,
  input  logic [CNT_W-1:0]  i_start,
  input  logic [CNT_W-1:0]  i_dur,
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic [DATA_W-1:0] i_data,
`ifdef FI_HITCOUNT_EN
  output logic [CNT_W-1:0]  o_hits,
`endif
  output logic [DATA_W-1:0] o_data,
  output logic              o_apply,
  output logic              o_done
);
  fi_state_e         r_state;
  fi_mode_e          r_mode;
  logic [DATA_W-1:0] r_mask, w_f;
  logic [CNT_W-1:0]  r_start, r_dur, r_rem;
  logic              w_load, w_last;
  // A config load overrides the old fault this cycle; DISARM lets the current cycle finish.
  assign w_load  = i_we && i_mode != FI_DISARM;
  assign o_apply = !rst && !w_load && (r_state == ST_ACTIVE || (r_state == ST_ARMED && i_cnt == r_start));
  // r_rem counts applying cycles still owed after the current one.
  assign w_last  = r_dur != '0 && (r_state == ST_ACTIVE ? r_rem == '0 : r_dur == CNT_W'(1));
  assign o_done  = o_apply && w_last && !i_we;
  assign w_f     = DATA_W'(fi_apply(FI_MAX_W'(i_data), FI_MAX_W'(r_mask), r_mode));
  assign o_data  = o_apply ? w_f : i_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= FI_FLIP;
      r_mask  <= '0;
      r_start <= '0;
      r_dur   <= '0;
      r_rem   <= '0;
    end else if (i_we) begin
      r_state <= w_load ? ST_ARMED : ST_IDLE;
      if (w_load) begin
        r_mode  <= i_mode;
        r_mask  <= i_mask;
        r_start <= i_start;
        r_dur   <= i_dur;
      end
    end else if (o_apply) begin
      r_state <= w_last ? ST_IDLE : ST_ACTIVE;
      r_rem   <= r_state == ST_ARMED ? r_dur - CNT_W'(2) : r_rem - CNT_W'(1);
    end
  end
`ifdef FI_HITCOUNT_EN
  logic [CNT_W-1:0] r_hits;
  always_ff @(posedge clk) begin
    if (rst || i_we) r_hits <= '0;
    else if (o_apply && w_f != i_data && r_hits != '1) r_hits <= r_hits + CNT_W'(1);
  end
  assign o_hits = r_hits;
`endif
endmodule

// File: rtl/fi_inject_ctrl.sv
// fi_inject_ctrl: run-time configurable fault injector on NUM_CH datapath buses.
// Ports: dla_core_clk/dla_core_rst, data_in/data_out (1-cycle registered),
// cfg_we/cfg_ch/cfg_mode/cfg_mask/cfg_start/cfg_dur config write, cycle_cnt,
// inj_active, inj_done, hit_cnt (only with FI_HITCOUNT_EN).
module fi_inject_ctrl
  import fi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                                      dla_core_clk,
  input  logic                                      dla_core_rst,
  input  logic [NUM_CH*DATA_W-1:0]                  data_in,
  output logic [NUM_CH*DATA_W-1:0]                  data_out,
  input  logic                                      cfg_we,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [FI_MODE_W-1:0]                      cfg_mode,
  input  logic [DATA_W-1:0]                         cfg_mask,
  input  logic [CNT_W-1:0]                          cfg_start,
  input  logic [CNT_W-1:0]                          cfg_dur,
  output logic [CNT_W-1:0]                          cycle_cnt,
  output logic [NUM_CH-1:0]                         inj_active,
  output logic [NUM_CH-1:0]                         inj_done
`ifdef FI_HITCOUNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]                   hit_cnt
`endif
);
  logic [CNT_W-1:0]         r_cnt;
  logic [NUM_CH*DATA_W-1:0] r_data_out, w_data_nxt;
  always_ff @(posedge dla_core_clk) begin
    r_cnt      <= dla_core_rst ? '0 : r_cnt + CNT_W'(1);
    r_data_out <= dla_core_rst ? '0 : w_data_nxt;
  end
  assign cycle_cnt = r_cnt;
  assign data_out  = r_data_out;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    fi_channel #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_ch (
      .clk     (dla_core_clk),
      .rst     (dla_core_rst),
      .i_we    (cfg_we && int'(cfg_ch) == k),
      .i_mode  (fi_mode_e'(cfg_mode)),
      .i_mask  (cfg_mask),
      .i_start (cfg_start),
      .i_dur   (cfg_dur),
      .i_cnt   (r_cnt),
      .i_data  (data_in[k*DATA_W +: DATA_W]),
`ifdef FI_HITCOUNT_EN
      .o_hits  (hit_cnt[k*CNT_W +: CNT_W]),
`endif
      .o_data  (w_data_nxt[k*DATA_W +: DATA_W]),
      .o_apply (inj_active[k]),
      .o_done  (inj_done[k])
    );
  end
endmodule

// File: tb/tb_fi_inject_ctrl.sv
// tb_fi_inject_ctrl: directed scoreboard bench for fi_inject_ctrl.
module tb_fi_inject_ctrl;
  import fi_pkg::*;
  logic clk = 1'b0, rst = 1'b1, rst4 = 1'b1;
  always #5 clk = ~clk;
  logic [127:0] din, dout;
  logic we;
  logic [1:0] ch, mode;
  logic [31:0] mask, start, dur, cnt;
  logic [3:0] act, done;
  logic [7:0] din4, dout4, mask4;
  logic we4, ch4, act4, done4;
  logic [1:0] mode4;
  logic [3:0] start4, dur4, cnt4;
`ifdef FI_HITCOUNT_EN
  logic [127:0] hits;
  logic [3:0] hits4;
`endif

  fi_inject_ctrl dut (
    .dla_core_clk(clk), .dla_core_rst(rst), .data_in(din), .data_out(dout),
    .cfg_we(we), .cfg_ch(ch), .cfg_mode(mode), .cfg_mask(mask), .cfg_start(start), .cfg_dur(dur),
    .cycle_cnt(cnt), .inj_active(act), .inj_done(done)
`ifdef FI_HITCOUNT_EN
    , .hit_cnt(hits)
`endif
  );

  fi_inject_ctrl #(.DATA_W(8), .NUM_CH(1), .CNT_W(4)) dut4 (
    .dla_core_clk(clk), .dla_core_rst(rst4), .data_in(din4), .data_out(dout4),
    .cfg_we(we4), .cfg_ch(ch4), .cfg_mode(mode4), .cfg_mask(mask4), .cfg_start(start4), .cfg_dur(dur4),
    .cycle_cnt(cnt4), .inj_active(act4), .inj_done(done4)
`ifdef FI_HITCOUNT_EN
    , .hit_cnt(hits4)
`endif
  );

  typedef struct {
    int t;
    logic [31:0] cnt;
    logic [3:0] act, done;
    logic [127:0] dout;
    logic [3:0] cnt4;
    logic act4, done4;
    logic [7:0] dout4;
    bit hit;
    logic [31:0] hit0, hit1;
  } item_t;

  item_t q[$];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input int t, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s t=%0d got=%h exp=%h", nm, t, a, e);
  endtask

  function automatic bit inr(input int v, input int lo, input int hi);
    return v >= lo && v <= hi;
  endfunction

  function automatic logic [127:0] exp_sample(input int s);
    logic [31:0] c0, c1, c2;
    c0 = s >= 60 ? (32'(s & 1) ^ 32'(inr(s, 65, 72))) : inr(s, 10, 12) ? 32'hF : s == 25 ? 32'h100 : 32'h0;
    c1 = inr(s, 50, 51) ? 32'h0000FFFF : 32'hFFFFFFFF;
    c2 = inr(s, 5, 20) ? 32'h92345678 : 32'h12345678;
    return {32'hA5A5A5A5, c2, c1, c0};
  endfunction

  task automatic cfg(input int c, input int m, input logic [31:0] k, input logic [31:0] s, input logic [31:0] d);
    we = 1'b1;
    ch = 2'(c);
    mode = 2'(m);
    mask = k;
    start = s;
    dur = d;
  endtask

  initial begin : monitor
    item_t m;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        m = q.pop_front();
        chk("cycle_cnt", m.t, 128'(cnt), 128'(m.cnt));
        chk("inj_active", m.t, 128'(act), 128'(m.act));
        chk("inj_done", m.t, 128'(done), 128'(m.done));
        chk("data_out", m.t, dout, m.dout);
        chk("cycle_cnt4", m.t, 128'(cnt4), 128'(m.cnt4));
        chk("inj_active4", m.t, 128'(act4), 128'(m.act4));
        chk("inj_done4", m.t, 128'(done4), 128'(m.done4));
        chk("data_out4", m.t, 128'(dout4), 128'(m.dout4));
`ifdef FI_HITCOUNT_EN
        if (m.hit) begin
          chk("hit_cnt0", m.t, 128'(hits[31:0]), 128'(m.hit0));
          chk("hit_cnt1", m.t, 128'(hits[63:32]), 128'(m.hit1));
        end
`endif
      end
    end
  end

  initial begin : driver
    item_t it;
    din = '0; we = 1'b0; ch = '0; mode = '0; mask = '0; start = '0; dur = '0;
    din4 = 8'h3C; we4 = 1'b0; ch4 = 1'b0; mode4 = 2'd0; mask4 = 8'hFF; start4 = 4'd2; dur4 = 4'd5;
    $display("hit counter %s", FI_HIT_EN ? "enabled" : "disabled");
    repeat (3) @(negedge clk);
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      rst = 1'b0;
      rst4 = t == 20;
      din = {32'hA5A5A5A5, 32'h12345678, 32'hFFFFFFFF, t >= 60 ? 32'(t & 1) : 32'h0};
      we = 1'b0;
      we4 = t == 9;
      case (t)
        1:  cfg(0, 0, 32'h0000000F, 10, 3);
        2:  cfg(2, 2, 32'h80000000, 5, 0);
        3:  cfg(1, 0, 32'h000000FF, 30, 4);
        15: cfg(0, 2, 32'h00000100, 25, 1);
        20: cfg(2, 3, 32'h0, 0, 0);
        30: cfg(1, 1, 32'hFFFF0000, 50, 2);
        35: cfg(3, 0, 32'h0, 40, 2);
        60: cfg(0, 0, 32'h1, 65, 8);
        61: cfg(1, 2, 32'h1, 65, 8);
        default: ;
      endcase
      it.t = t;
      it.cnt = t;
      it.act = {inr(t, 40, 41), inr(t, 5, 20), inr(t, 50, 51) || inr(t, 65, 72), inr(t, 10, 12) || t == 25 || inr(t, 65, 72)};
      it.done = {t == 41, 1'b0, t == 51 || t == 72, t == 12 || t == 25 || t == 72};
      it.dout = t == 0 ? 128'h0 : exp_sample(t - 1);
      it.cnt4 = t <= 20 ? 4'(t) : 4'(t - 21);
      it.act4 = inr(t, 18, 19);
      it.done4 = 1'b0;
      it.dout4 = (t == 0 || t == 21) ? 8'h00 : inr(t, 19, 20) ? 8'hC3 : 8'h3C;
      it.hit = t == 75;
      it.hit0 = 32'd8;
      it.hit1 = 32'd0;
      q.push_back(it);
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
